// File: rtl/player_bullet_ctrl.sv
// Player bullet: launches on fire edge, climbs per move tick,
// retires at the top edge or on hit, then cools down.
module player_bullet_ctrl #(
  parameter int unsigned MOVE_DIV  = 250000,
  parameter int unsigned SPEED     = 4,
  parameter int unsigned COOLDOWN  = 8,
  parameter int unsigned MUZZLE_DX = 20,
  parameter int unsigned B_H       = 10,
  parameter int unsigned X_MAX     = 639
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire,
  input  logic [9:0] pl_x,
  input  logic [9:0] pl_y,
  input  logic       hit,
  output logic [9:0] b_x,
  output logic [9:0] b_y,
  output logic       mybullet_en,
  output logic       shot
);

  localparam int unsigned COOL_EFF =
    (COOLDOWN == 0) ? 1 : COOLDOWN;
  localparam int DIV_W =
    (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int CNT_W =
    (COOL_EFF > 1) ? $clog2(COOL_EFF) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(MOVE_DIV - 1);
  localparam logic [CNT_W-1:0] COOL_LAST =
    CNT_W'(COOL_EFF - 1);
  localparam logic [9:0]  SPEED_V = 10'(SPEED);
  localparam logic [9:0]  B_H_V   = 10'(B_H);
  localparam logic [10:0] DX_V    = 11'(MUZZLE_DX);
  localparam logic [10:0] XMAX_11 = 11'(X_MAX);
  localparam logic [9:0]  XMAX_V  = 10'(X_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLY,
    S_COOL
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [DIV_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] r_cool_cnt;
  logic [CNT_W-1:0] w_cool_nx;
  logic             r_fire_q;
  logic [9:0]       r_b_x;
  logic [9:0]       r_b_y;
  logic             r_en;
  logic             r_shot;

  logic [9:0]  w_b_x_nx;
  logic [9:0]  w_b_y_nx;
  logic        w_en_nx;
  logic        w_shot_nx;
  logic        w_tick;
  logic        w_fire_rise;
  logic [10:0] w_spawn_x11;
  logic [9:0]  w_spawn_x;
  logic [9:0]  w_spawn_y;

  assign w_tick      = (r_div_cnt == DIV_LAST);
  assign w_fire_rise = fire & ~r_fire_q;

  // Muzzle offset may overflow 10 bits; clamp at the right edge.
  assign w_spawn_x11 = {1'b0, pl_x} + DX_V;
  assign w_spawn_x   = (w_spawn_x11 > XMAX_11) ?
                       XMAX_V : w_spawn_x11[9:0];
  assign w_spawn_y   = (pl_y >= B_H_V) ?
                       (pl_y - B_H_V) : 10'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cool_nx  = r_cool_cnt;
    w_b_x_nx   = r_b_x;
    w_b_y_nx   = r_b_y;
    w_en_nx    = r_en;
    w_shot_nx  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fire_rise) begin
          w_b_x_nx   = w_spawn_x;
          w_b_y_nx   = w_spawn_y;
          w_en_nx    = 1'b1;
          w_shot_nx  = 1'b1;
          w_state_nx = S_FLY;
        end
      end
      S_FLY: begin
        // A hit outranks a move on the same cycle.
        if (hit) begin
          w_en_nx    = 1'b0;
          w_cool_nx  = '0;
          w_state_nx = S_COOL;
        end else if (w_tick && (r_b_y < SPEED_V)) begin
          w_en_nx    = 1'b0;
          w_cool_nx  = '0;
          w_state_nx = S_COOL;
        end else if (w_tick) begin
          w_b_y_nx   = r_b_y - SPEED_V;
        end
      end
      S_COOL: begin
        if (w_tick) begin
          if (r_cool_cnt == COOL_LAST) begin
            w_state_nx = S_IDLE;
          end else begin
            w_cool_nx  = r_cool_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_en_nx    = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Held button across reset must not count as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fire_q   <= 1'b1;
      r_cool_cnt <= '0;
      r_b_x      <= '0;
      r_b_y      <= '0;
      r_en       <= 1'b0;
      r_shot     <= 1'b0;
    end else begin
      r_fire_q   <= fire;
      r_cool_cnt <= w_cool_nx;
      r_b_x      <= w_b_x_nx;
      r_b_y      <= w_b_y_nx;
      r_en       <= w_en_nx;
      r_shot     <= w_shot_nx;
    end
  end

  assign b_x         = r_b_x;
  assign b_y         = r_b_y;
  assign mybullet_en = r_en;
  assign shot        = r_shot;

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// Bench for player_bullet_ctrl: expected bullet events are
// queued by stimulus and matched by a negedge monitor.
module tb_player_bullet_ctrl;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       fire = 1'b0;
  logic       hit  = 1'b0;
  logic [9:0] pl_x = '0;
  logic [9:0] pl_y = '0;
  logic [9:0] b_x;
  logic [9:0] b_y;
  logic       mybullet_en;
  logic       shot;

  player_bullet_ctrl #(
    .MOVE_DIV (4),
    .SPEED    (4),
    .COOLDOWN (2),
    .MUZZLE_DX(20),
    .B_H      (10),
    .X_MAX    (639)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fire       (fire),
    .pl_x       (pl_x),
    .pl_y       (pl_y),
    .hit        (hit),
    .b_x        (b_x),
    .b_y        (b_y),
    .mybullet_en(mybullet_en),
    .shot       (shot)
  );

  always #5 clk = ~clk;

  localparam int K_LAUNCH = 0;
  localparam int K_MOVE   = 1;
  localparam int K_RETIRE = 2;

  typedef struct {
    int         kind;
    logic [9:0] bx;
    logic [9:0] by;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  phase  = 0;

  // Bench-side view of the move-tick phase (tick when phase==3).
  always @(posedge clk)
    phase <= rst ? 0 : ((phase == 3) ? 0 : phase + 1);

  logic       prev_en = 1'b0;
  logic [9:0] prev_by = '0;

  task automatic score(int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d b_x=%0d b_y=%0d",
               k, b_x, b_y);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || b_y !== e.by ||
          (k == K_LAUNCH &&
           (b_x !== e.bx || mybullet_en !== 1'b1))) begin
        errors++;
        $display("FAIL event got kind=%0d x=%0d y=%0d exp kind=%0d x=%0d y=%0d",
                 k, b_x, b_y, e.kind, e.bx, e.by);
      end
    end
  endtask

  always @(negedge clk) begin
    int  k;
    bit  ev;
    ev = 1'b0;
    k  = 0;
    if (shot === 1'b1) begin
      k = K_LAUNCH; ev = 1'b1;
    end else if (prev_en === 1'b1 && mybullet_en === 1'b0) begin
      k = K_RETIRE; ev = 1'b1;
    end else if (mybullet_en === 1'b1 && b_y !== prev_by) begin
      k = K_MOVE; ev = 1'b1;
    end
    if (ev) score(k);
    prev_en = mybullet_en;
    prev_by = b_y;
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick();
    int g;
    g = 0;
    while (phase != 3 && g < 8) begin
      step();
      g++;
    end
    if (phase != 3) begin
      checks++;
      errors++;
      $display("FAIL tick_wait phase=%0d required=3", phase);
    end
  endtask

  task automatic tick_n(int n);
    for (int i = 0; i < n; i++) begin
      wait_tick();
      step();
    end
  endtask

  task automatic push(int k, int bx, int by);
    ev_t e;
    e.kind = k;
    e.bx   = 10'(bx);
    e.by   = 10'(by);
    exp_q.push_back(e);
  endtask

  task automatic chk(string nm, logic [9:0] act, logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic fire_pulse();
    fire = 1'b1;
    step();
    fire = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: fire held through reset must not launch
    rst  = 1'b1;
    fire = 1'b1;
    step(3);
    chk("rst_b_x", b_x, 10'd0);
    chk("rst_b_y", b_y, 10'd0);
    chk("rst_en", {9'd0, mybullet_en}, 10'd0);
    chk("rst_shot", {9'd0, shot}, 10'd0);
    rst = 1'b0;
    step(3);
    hit = 1'b1;
    step();
    hit = 1'b0;
    step(3);
    fire = 1'b0;
    step();

    // 2/3: launch at (120,390), climb to 2, retire at top
    pl_x = 10'd100;
    pl_y = 10'd400;
    push(K_LAUNCH, 120, 390);
    for (int y = 386; y >= 2; y -= 4) push(K_MOVE, 0, y);
    push(K_RETIRE, 0, 2);
    fire_pulse();
    tick_n(98);
    chk("top_en", {9'd0, mybullet_en}, 10'd0);
    chk("top_by", b_y, 10'd2);
    hit = 1'b1;
    step();
    hit = 1'b0;
    tick_n(1);
    wait_tick();
    fire = 1'b1;
    step();
    fire = 1'b0;
    step();

    // 4: hit on a tick cycle at 300 wins over the move
    pl_y = 10'd410;
    push(K_LAUNCH, 120, 400);
    for (int y = 396; y >= 300; y -= 4) push(K_MOVE, 0, y);
    push(K_RETIRE, 0, 300);
    fire_pulse();
    tick_n(25);
    wait_tick();
    hit = 1'b1;
    step();
    hit = 1'b0;
    chk("hit_by", b_y, 10'd300);
    fire_pulse();
    tick_n(2);
    step();

    // 5: x clamp and y floor, retire on first tick
    pl_x = 10'd630;
    pl_y = 10'd5;
    push(K_LAUNCH, 639, 0);
    push(K_RETIRE, 0, 0);
    fire_pulse();
    tick_n(1);
    tick_n(2);
    step();

    // 6: reset mid-flight at 200, then a normal launch
    pl_x = 10'd300;
    pl_y = 10'd214;
    push(K_LAUNCH, 320, 204);
    push(K_MOVE, 0, 200);
    push(K_RETIRE, 0, 0);
    fire_pulse();
    tick_n(1);
    chk("pre_rst_by", b_y, 10'd200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_b_x", b_x, 10'd0);
    chk("mid_rst_b_y", b_y, 10'd0);
    chk("mid_rst_shot", {9'd0, shot}, 10'd0);
    step(2);
    pl_x = 10'd50;
    pl_y = 10'd50;
    push(K_LAUNCH, 70, 40);
    push(K_MOVE, 0, 36);
    push(K_RETIRE, 0, 36);
    fire_pulse();
    tick_n(1);
    hit = 1'b1;
    step();
    hit = 1'b0;
    step(6);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d required=0",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
